// File: rtl/mult_axi_lite_master.sv
// rtl/mult_axi_lite_master.sv - AXI4-Lite master driving the memory-mapped multiplier slave
//
// Accepts an operand pair on cmd_*, writes A to BASE+0x0 and B to BASE+0x4,
// reads the product low word from BASE+0x8 and the overflow flag from BASE+0xC,
// then presents res_data/res_ovf/res_err on res_* until res_ready.
//
// Ports:
//   m_axi_aclk, m_axi_areset     clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_a/b  operand pair command
//   res_valid/res_ready          result handshake
//   res_data/res_ovf/res_err     product low word, overflow bit, error bit
//   m_axi_aw*/w*/b*/ar*/r*       AXI4-Lite master bus (1-bit responses)
module mult_axi_lite_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int BASE_ADDR      = 0,
    parameter int OKAY_RESP      = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    res_ovf,
    output logic                    res_err,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8:0]   m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic                    m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic                    m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_LO, RD_OVF, RESP} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_A   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_B   = ADDR_WIDTH'(BASE_ADDR + 4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LO  = ADDR_WIDTH'(BASE_ADDR + 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OVF = ADDR_WIDTH'(BASE_ADDR + 12);
    localparam logic                  OKAY_BIT = 1'(OKAY_RESP);
    localparam int                    CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]         T_LAST   = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   op_a;
    logic [DATA_WIDTH-1:0]   op_b;
    logic                    launched;
    logic                    aw_done, w_done, b_done, ar_done, r_done;
    logic [CW-1:0]           cnt;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_n, w_n, b_n, ar_n, r_n;
    logic wr_complete, rd_complete, timeout_hit;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = m_axi_bvalid & m_axi_bready;
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rvalid & m_axi_rready;

    // Flags including this cycle's handshakes, so a completion seen on the
    // same edge as the last handshake exits without waiting a cycle.
    assign aw_n = aw_done | aw_hs;
    assign w_n  = w_done | w_hs;
    assign b_n  = b_done | b_hs;
    assign ar_n = ar_done | ar_hs;
    assign r_n  = r_done | r_hs;

    assign wr_complete = aw_n & w_n & b_n;
    assign rd_complete = ar_n & r_n;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == T_LAST);

    assign m_axi_wstrb = '1;

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_ovf       <= 1'b0;
            res_err       <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            op_a          <= '0;
            op_b          <= '0;
            launched      <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            b_done        <= 1'b0;
            ar_done       <= 1'b0;
            r_done        <= 1'b0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_a      <= cmd_a;
                        op_b      <= cmd_b;
                        res_err   <= 1'b0;
                        res_data  <= '0;
                        res_ovf   <= 1'b0;
                        launched  <= 1'b0;
                        cnt       <= '0;
                        cmd_ready <= 1'b0;
                        state     <= WR_A;
                    end
                end

                WR_A, WR_B: begin
                    if (state == WR_A && !launched) begin
                        // The accept edge only latches operands; the first
                        // write is launched from the registered copy.
                        m_axi_awaddr  <= ADDR_A;
                        m_axi_wdata   <= op_a;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        m_axi_bready  <= 1'b1;
                        launched      <= 1'b1;
                        cnt           <= cnt + 1'b1;
                    end else begin
                        if (b_hs && m_axi_bresp != OKAY_BIT)
                            res_err <= 1'b1;
                        if (wr_complete) begin
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            b_done        <= 1'b0;
                            m_axi_awvalid <= 1'b0;
                            m_axi_wvalid  <= 1'b0;
                            m_axi_bready  <= 1'b0;
                            cnt           <= '0;
                            if (state == WR_A) begin
                                m_axi_awaddr  <= ADDR_B;
                                m_axi_wdata   <= op_b;
                                m_axi_awvalid <= 1'b1;
                                m_axi_wvalid  <= 1'b1;
                                m_axi_bready  <= 1'b1;
                                state         <= WR_B;
                            end else begin
                                m_axi_araddr  <= ADDR_LO;
                                m_axi_arvalid <= 1'b1;
                                m_axi_rready  <= 1'b1;
                                state         <= RD_LO;
                            end
                        end else if (timeout_hit) begin
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            b_done        <= 1'b0;
                            m_axi_awvalid <= 1'b0;
                            m_axi_wvalid  <= 1'b0;
                            m_axi_bready  <= 1'b0;
                            res_err       <= 1'b1;
                            state         <= RESP;
                        end else begin
                            aw_done <= aw_n;
                            w_done  <= w_n;
                            b_done  <= b_n;
                            if (aw_hs) m_axi_awvalid <= 1'b0;
                            if (w_hs)  m_axi_wvalid  <= 1'b0;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                RD_LO, RD_OVF: begin
                    if (r_hs) begin
                        if (state == RD_LO) res_data <= m_axi_rdata;
                        else                res_ovf  <= m_axi_rdata[0];
                        if (m_axi_rresp != OKAY_BIT)
                            res_err <= 1'b1;
                    end
                    if (rd_complete) begin
                        ar_done       <= 1'b0;
                        r_done        <= 1'b0;
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b0;
                        cnt           <= '0;
                        if (state == RD_LO) begin
                            m_axi_araddr  <= ADDR_OVF;
                            m_axi_arvalid <= 1'b1;
                            m_axi_rready  <= 1'b1;
                            state         <= RD_OVF;
                        end else begin
                            state <= RESP;
                        end
                    end else if (timeout_hit) begin
                        ar_done       <= 1'b0;
                        r_done        <= 1'b0;
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b0;
                        res_err       <= 1'b1;
                        state         <= RESP;
                    end else begin
                        ar_done <= ar_n;
                        r_done  <= r_n;
                        if (ar_hs) m_axi_arvalid <= 1'b0;
                        cnt <= cnt + 1'b1;
                    end
                end

                RESP: begin
                    // Result registers settle on entry; res_valid follows one
                    // cycle later and they stay frozen until consumed.
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mult_axi_lite_master.md
Name: mult_axi_lite_master

Overview:
AXI4-Lite master that sits directly upstream of the memory-mapped multiplier slave and drives its s2_axi port.
It accepts an operand pair on a valid/ready command interface and runs four bus transactions in order: write operand A (offset 0x0), write operand B (0x4), read the product's low word (0x8), read the overflow flag (0xC).
It then returns the product, the overflow bit and an error bit on a valid/ready result interface.
A per-transaction timeout counter prevents a hung slave from locking the block.

Parameters:
DATA_WIDTH, 32, bus data width and operand/result width.
ADDR_WIDTH, 8, bus address width.
BASE_ADDR, 0, slave base address; offsets 0x0/0x4/0x8/0xC are added to it.
OKAY_RESP, 1, value of the 1-bit bresp/rresp that means success (the multiplier slave returns 1).
TIMEOUT_CYCLES, 64, cycles allowed per transaction before abort; 0 disables the timeout.

Ports:
m_axi_aclk  in  1  clock
m_axi_areset  in  1  synchronous reset, active-high
cmd_valid  in  1  operand pair valid
cmd_ready  out  1  block idle, can accept a command
cmd_a  in  DATA_WIDTH  operand A
cmd_b  in  DATA_WIDTH  operand B
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  DATA_WIDTH  product low word
res_ovf  out  1  overflow flag (bit 0 of the 0xC read)
res_err  out  1  bad response or timeout occurred during this command
m_axi_awaddr  out  ADDR_WIDTH  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  DATA_WIDTH  write data
m_axi_wstrb  out  DATA_WIDTH/8+1  write strobes, all ones (width matches the slave port)
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  1  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  ADDR_WIDTH  read address
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  1  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready

Behaviour:
- Reset values: state=IDLE; cmd_ready=1; res_valid=0, res_data=0, res_ovf=0, res_err=0; awvalid=wvalid=arvalid=0; bready=rready=0; awaddr=araddr=0; wdata=0.
- A reset asserted mid-command aborts that command immediately with no result, and all valids drop on the next edge.
- States: IDLE, WR_A, WR_B, RD_LO, RD_OVF, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_a and cmd_b, clear err, and go to WR_A.
- Write states (WR_A uses addr BASE_ADDR+0 with data A; WR_B uses BASE_ADDR+4 with data B):
  - awvalid and wvalid are asserted together in the same cycle; bready=1 for the whole state.
  - aw_done, w_done and b_done are sticky flags. Each is set on its own handshake: awvalid&&awready, wvalid&&wready, bvalid&&bready.
  - awvalid drops the cycle after aw_done is set; wvalid drops the cycle after w_done is set.
  - A handshake may arrive in any order; bvalid arriving in the same cycle as awready/wready is legal and is counted.
  - The state exits on the edge where all three flags are (or become) set. The flags clear on exit.
  - If bresp != OKAY_RESP, set err and continue the sequence.
- Read states (RD_LO uses BASE_ADDR+8; RD_OVF uses BASE_ADDR+12):
  - arvalid is held until arready; rready=1 for the whole state.
  - On rvalid&&rready, capture the data: RD_LO stores rdata into res_data; RD_OVF stores rdata[0] into res_ovf.
  - If rresp != OKAY_RESP, set err.
  - The state exits when both ar_done and r_done are set. An rvalid in the same cycle as arready is accepted.
- State-to-state timing:
  - The next state's valids assert the cycle after the previous state exits; there is no extra bubble.
  - With the multiplier slave, each transaction completes in 2 cycles. res_valid rises 10 cycles after the cmd handshake edge.
- Timeout:
  - A counter resets on entry to each bus state.
  - If it reaches TIMEOUT_CYCLES-1 without the state completing, all valids/readies drop and err is set.
  - The remaining states are skipped and the block goes to RESP; res_data and res_ovf keep whatever has been captured so far (0 if nothing was captured).
- RESP: res_valid=1, and res_data/res_ovf/res_err are stable while res_ready=0. On res_ready, go to IDLE. cmd_ready=0 in every state except IDLE.
- Addresses are computed modulo 2^ADDR_WIDTH.

Test Plan:
- Slave model at BASE_ADDR 0; cmd A=6, B=7, res_ready=1 -> bus sees writes 0x0=6 and 0x4=7, reads 0x8 and 0xC; res_data=42, res_ovf=0, res_err=0; res_valid 10 cycles after the cmd handshake.
- A=0x0001_0000, B=0x0001_0000 -> res_data=0, res_ovf=1, res_err=0.
- Hold res_ready=0 for 5 cycles after res_valid -> outputs stable and cmd_ready=0 throughout; cmd_valid pulsed during the hold is ignored; the block returns to IDLE one cycle after res_ready.
- Slave delays wready 3 cycles after awready, with bvalid 1 cycle later -> awvalid drops after its own handshake; the write completes once; wdata is held until wready.
- Slave never asserts bvalid on the WR_B write, TIMEOUT_CYCLES=16 -> WR_B aborts after 16 cycles, no reads are issued, res_err=1.
- Slave returns bresp=0 on the 0x0 write, then behaves normally -> the full sequence runs, res_err=1, res_data is correct; reset asserted during RD_LO -> all valids are 0 after the next edge and no result is produced.
